// File: rtl/riscv_pkg.sv
// Slice of the riscv package: the domain type, the widths, and the cause code
// used by the JIT domain-switch sequencer.
package riscv;
    localparam int unsigned XLEN = 64;
    localparam int unsigned VLEN = 39;

    localparam logic [XLEN-1:0] ILLEGAL_INSTR = 64'd2;

    typedef enum logic [1:0] {
        DOMI = 2'd0,
        DOM0 = 2'd1,
        DOM1 = 2'd2,
        DOM2 = 2'd3
    } dmp_domain_t;

    localparam dmp_domain_t DMP_RESET_DOM = DOMI;
endpackage

// File: rtl/dmp_dom_stack.sv
// Return-domain LIFO. A push while full or a pop while empty is dropped, so
// the count always stays within 0..StackDepth.
module dmp_dom_stack
    import riscv::*;
#(
    parameter int unsigned StackDepth = 4,
    localparam int unsigned CntW = $clog2(StackDepth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            clear_i,
    input  dmp_domain_t     data_i,
    output dmp_domain_t     top_o,
    output logic [CntW-1:0] cnt_o,
    output logic            full_o,
    output logic            empty_o
);
    dmp_domain_t     mem_q [StackDepth];
    dmp_domain_t     mem_d [StackDepth];
    logic [CntW-1:0] cnt_q, cnt_d;

    assign full_o  = (cnt_q == CntW'(StackDepth));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;

    always_comb begin
        top_o = mem_q[0];
        for (int i = 0; i < StackDepth; i++) begin
            if (cnt_q == CntW'(i + 1)) top_o = mem_q[i];
        end
    end

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (push_i && !full_o) begin
            for (int i = 0; i < StackDepth; i++) begin
                if (cnt_q == CntW'(i)) mem_d[i] = data_i;
            end
            cnt_d = cnt_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            for (int i = 0; i < StackDepth; i++) mem_q[i] <= DMP_RESET_DOM;
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/dmp_domain_ctrl.sv
// Commit-stage sequencer for chdom/retdom: holds commit, drains the frontend
// through a flush handshake, then switches the current domain.
module dmp_domain_ctrl
    import riscv::*;
#(
    parameter int unsigned  StackDepth = 4,
    parameter dmp_domain_t  ResetDom   = DMP_RESET_DOM,
    localparam int unsigned CntW       = $clog2(StackDepth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            commit_valid_i,
    output logic            commit_ready_o,
    input  logic            commit_chg_dom_i,
    input  logic            commit_ret_i,
    input  dmp_domain_t     commit_target_dom_i,
    input  logic [VLEN-1:0] commit_pc_i,
    input  logic            trap_i,
    output logic            flush_req_o,
    input  logic            flush_ack_i,
    output dmp_domain_t     curdom_o,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_cause_o,
    output logic [XLEN-1:0] ex_tval_o,
    output logic [CntW-1:0] stack_cnt_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, EXC = 2'd2} state_e;

    state_e          state_q, state_d;
    dmp_domain_t     curdom_q, curdom_d;
    dmp_domain_t     tgt_q, tgt_d;
    logic            ret_q, ret_d;
    logic [VLEN-1:0] pc_q, pc_d;

    dmp_domain_t     stk_top;
    logic            stk_full, stk_empty;
    logic            hs, ack;

    // A trap in the same cycle overrides both the commit and the flush ack.
    assign hs  = commit_valid_i && commit_ready_o && !trap_i;
    assign ack = (state_q == FLUSH) && flush_ack_i && !trap_i;

    assign commit_ready_o = (state_q == IDLE);
    assign flush_req_o    = (state_q == FLUSH) && !trap_i;
    assign ex_valid_o     = (state_q == EXC) && !trap_i;
    assign ex_cause_o     = ex_valid_o ? ILLEGAL_INSTR : '0;
    assign ex_tval_o      = ex_valid_o ? XLEN'(pc_q) : '0;
    assign curdom_o       = curdom_q;

    dmp_dom_stack #(.StackDepth(StackDepth)) i_stack (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (ack && !ret_q),
        .pop_i   (ack && ret_q),
        .clear_i (trap_i),
        .data_i  (curdom_q),
        .top_o   (stk_top),
        .cnt_o   (stack_cnt_o),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_comb begin
        state_d  = state_q;
        curdom_d = curdom_q;
        tgt_d    = tgt_q;
        ret_d    = ret_q;
        pc_d     = pc_q;
        if (trap_i) begin
            state_d  = IDLE;
            curdom_d = ResetDom;
        end else begin
            unique case (state_q)
                IDLE: if (hs && commit_chg_dom_i) begin
                    tgt_d = commit_target_dom_i;
                    ret_d = commit_ret_i;
                    pc_d  = commit_pc_i;
                    if ((commit_ret_i && stk_empty) || (!commit_ret_i && stk_full))
                        state_d = EXC;
                    else
                        state_d = FLUSH;
                end
                FLUSH: if (ack) begin
                    curdom_d = ret_q ? stk_top : tgt_q;
                    state_d  = IDLE;
                end
                EXC:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            curdom_q <= ResetDom;
            tgt_q    <= ResetDom;
            ret_q    <= 1'b0;
            pc_q     <= '0;
        end else begin
            state_q  <= state_d;
            curdom_q <= curdom_d;
            tgt_q    <= tgt_d;
            ret_q    <= ret_d;
            pc_q     <= pc_d;
        end
    end
endmodule

// File: tb/tb_dmp_domain_ctrl.sv
// Directed bench for dmp_domain_ctrl: stimulus pushes expected domain-change
// and exception events; a negedge monitor pops and compares them.
module tb_dmp_domain_ctrl;
    import riscv::*;

    localparam int Depth = 4;
    localparam int CntW  = $clog2(Depth + 1);

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            commit_valid_i, commit_ready_o, commit_chg_dom_i, commit_ret_i;
    dmp_domain_t     commit_target_dom_i;
    logic [VLEN-1:0] commit_pc_i;
    logic            trap_i, flush_req_o, flush_ack_i, ex_valid_o;
    dmp_domain_t     curdom_o;
    logic [XLEN-1:0] ex_cause_o, ex_tval_o;
    logic [CntW-1:0] stack_cnt_o;

    always #5 clk = ~clk;

    dmp_domain_ctrl #(.StackDepth(Depth), .ResetDom(DOMI)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .commit_valid_i      (commit_valid_i),
        .commit_ready_o      (commit_ready_o),
        .commit_chg_dom_i    (commit_chg_dom_i),
        .commit_ret_i        (commit_ret_i),
        .commit_target_dom_i (commit_target_dom_i),
        .commit_pc_i         (commit_pc_i),
        .trap_i              (trap_i),
        .flush_req_o         (flush_req_o),
        .flush_ack_i         (flush_ack_i),
        .curdom_o            (curdom_o),
        .ex_valid_o          (ex_valid_o),
        .ex_cause_o          (ex_cause_o),
        .ex_tval_o           (ex_tval_o),
        .stack_cnt_o         (stack_cnt_o)
    );

    typedef struct {
        bit          is_exc;
        dmp_domain_t dom;
        int          cnt;
        logic [63:0] tval;
        string       name;
    } ev_t;

    ev_t         exp_q[$];
    dmp_domain_t m_dom;
    dmp_domain_t m_stk[$];
    int          n_pass = 0;
    int          n_tot  = 0;
    bit          mon_en = 1'b0;
    dmp_domain_t prev_dom;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: every exception pulse and every curdom change must match the
    // next expected event in order.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if (ex_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_tot++;
                    $display("FAIL unexpected_exc: got tval %0h expected no event", ex_tval_o);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_kind"}, 64'(e.is_exc), 64'd1);
                    chk({e.name, "_tval"}, ex_tval_o, e.tval);
                    chk({e.name, "_cause"}, ex_cause_o, ILLEGAL_INSTR);
                    chk({e.name, "_dom"}, 64'(curdom_o), 64'(e.dom));
                    chk({e.name, "_cnt"}, 64'(stack_cnt_o), 64'(e.cnt));
                end
            end
            if (curdom_o !== prev_dom) begin
                if (exp_q.size() == 0) begin
                    n_tot++;
                    $display("FAIL unexpected_dom: got %0d expected %0d", curdom_o, prev_dom);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_kind"}, 64'(e.is_exc), 64'd0);
                    chk({e.name, "_dom"}, 64'(curdom_o), 64'(e.dom));
                    chk({e.name, "_cnt"}, 64'(stack_cnt_o), 64'(e.cnt));
                end
            end
        end
        prev_dom = curdom_o;
    end

    task automatic push_dom_ev(input dmp_domain_t d, input string nm);
        ev_t e;
        e.is_exc = 1'b0; e.dom = d; e.cnt = m_stk.size(); e.tval = '0; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Entered and left at posedge+#1. ack_dly = 0 leaves the DUT in FLUSH.
    task automatic do_chg(input dmp_domain_t tgt, input bit ret, input logic [VLEN-1:0] pc,
                          input int ack_dly, input string nm);
        bit          exc;
        dmp_domain_t nd;
        ev_t         e;
        exc = (ret && m_stk.size() == 0) || (!ret && m_stk.size() == Depth);
        if (exc) begin
            e.is_exc = 1'b1; e.dom = m_dom; e.cnt = m_stk.size(); e.tval = 64'(pc); e.name = nm;
            exp_q.push_back(e);
        end else if (ack_dly > 0) begin
            if (ret) begin nd = m_stk[$]; m_stk.pop_back(); end
            else begin m_stk.push_back(m_dom); nd = tgt; end
            if (nd != m_dom) push_dom_ev(nd, nm);
            m_dom = nd;
        end
        commit_valid_i = 1'b1; commit_chg_dom_i = 1'b1; commit_ret_i = ret;
        commit_target_dom_i = tgt; commit_pc_i = pc;
        @(posedge clk); #1;
        commit_valid_i = 1'b0; commit_chg_dom_i = 1'b0; commit_ret_i = 1'b0;
        if (exc) begin
            @(negedge clk);
            chk({nm, "_exc_ready"}, 64'(commit_ready_o), 64'd0);
            chk({nm, "_exc_noflush"}, 64'(flush_req_o), 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk({nm, "_exc_pulse_end"}, 64'(ex_valid_o), 64'd0);
            chk({nm, "_exc_ready_back"}, 64'(commit_ready_o), 64'd1);
            @(posedge clk); #1;
        end else if (ack_dly > 0) begin
            for (int k = 1; k <= ack_dly; k++) begin
                flush_ack_i = (k == ack_dly);
                @(negedge clk);
                chk($sformatf("%s_flush_req%0d", nm, k), 64'(flush_req_o), 64'd1);
                chk($sformatf("%s_hold%0d", nm, k), 64'(commit_ready_o), 64'd0);
                @(posedge clk); #1;
            end
            flush_ack_i = 1'b0;
            @(negedge clk);
            chk({nm, "_ready_back"}, 64'(commit_ready_o), 64'd1);
            chk({nm, "_flush_done"}, 64'(flush_req_o), 64'd0);
            chk({nm, "_cnt"}, 64'(stack_cnt_o), 64'(m_stk.size()));
            @(posedge clk); #1;
        end
    endtask

    task automatic check_idle_reset(input string nm);
        chk({nm, "_curdom"}, 64'(curdom_o), 64'(DOMI));
        chk({nm, "_cnt"}, 64'(stack_cnt_o), 64'd0);
        chk({nm, "_ready"}, 64'(commit_ready_o), 64'd1);
        chk({nm, "_flush"}, 64'(flush_req_o), 64'd0);
        chk({nm, "_exv"}, 64'(ex_valid_o), 64'd0);
        chk({nm, "_cause"}, ex_cause_o, 64'd0);
        chk({nm, "_tval"}, ex_tval_o, 64'd0);
    endtask

    task automatic do_trap(input string nm);
        if (m_dom != DOMI) begin m_stk.delete(); push_dom_ev(DOMI, nm); end
        m_stk.delete(); m_dom = DOMI;
        trap_i = 1'b1;
        @(posedge clk); #1;
        trap_i = 1'b0;
        @(negedge clk);
        chk({nm, "_curdom"}, 64'(curdom_o), 64'(DOMI));
        chk({nm, "_cnt"}, 64'(stack_cnt_o), 64'd0);
        chk({nm, "_flush"}, 64'(flush_req_o), 64'd0);
        chk({nm, "_ready"}, 64'(commit_ready_o), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc;
        rst_ni = 1'b0; commit_valid_i = 1'b0; commit_chg_dom_i = 1'b0; commit_ret_i = 1'b0;
        commit_target_dom_i = DOMI; commit_pc_i = '0; trap_i = 1'b0; flush_ack_i = 1'b0;
        m_dom = DOMI;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        check_idle_reset("reset");
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Stray ack in IDLE must not move anything.
        flush_ack_i = 1'b1;
        @(posedge clk); #1;
        flush_ack_i = 1'b0;
        @(negedge clk);
        chk("early_ack_cnt", 64'(stack_cnt_o), 64'd0);
        @(posedge clk); #1;

        do_chg(DOM1, 1'b0, 39'h1000, 3, "plain_chdom");
        do_chg(DOM0, 1'b1, 39'h1004, 1, "retdom");
        do_chg(DOM2, 1'b1, 39'h80000000, 1, "underflow");

        do_chg(DOM0, 1'b0, 39'h2000, 1, "fill0");
        do_chg(DOM1, 1'b0, 39'h2004, 1, "fill1");
        do_chg(DOM2, 1'b0, 39'h2008, 2, "fill2");
        do_chg(DOM0, 1'b0, 39'h200c, 1, "fill3");
        do_chg(DOM1, 1'b0, 39'h4000abcd, 1, "overflow");

        do_trap("trap_idle");
        do_chg(DOM1, 1'b0, 39'h3000, 1, "pre_trap0");
        do_chg(DOM2, 1'b0, 39'h3004, 2, "pre_trap1");
        do_chg(DOM0, 1'b0, 39'h3008, 0, "trap_sw");
        do_trap("trap_flush");

        acc = 0;
        commit_valid_i = 1'b1; commit_chg_dom_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (commit_ready_o) acc++;
            @(posedge clk); #1;
        end
        commit_valid_i = 1'b0;
        chk("noop_accepted", 64'(acc), 64'd10);

        do_chg(DOM1, 1'b0, 39'h5000, 1, "pre_rst");
        do_chg(DOM2, 1'b0, 39'h5004, 0, "rst_sw");
        m_stk.delete(); push_dom_ev(DOMI, "mid_rst"); m_dom = DOMI;
        rst_ni = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(negedge clk);
        check_idle_reset("mid_rst");
        repeat (2) @(posedge clk);

        chk("events_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
